// File: rtl/axis_rr_packet_mux_if.sv
// AXI-Stream bundle shared by the mux's input side (NUM lanes) and output side (single lane).
`timescale 1ns/1ps
interface axis_rr_packet_mux_if #(
  parameter int unsigned NUM        = 1,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ID_WIDTH   = 1
);
  logic [NUM-1:0]            tvalid;
  logic [NUM-1:0]            tready;
  logic [NUM-1:0]            tlast;
  logic [NUM*DATA_WIDTH-1:0] tdata;
  logic [ID_WIDTH-1:0]       tid;

  modport master (output tvalid, tdata, tlast, tid, input tready);
  modport slave  (input tvalid, tdata, tlast, output tready);
endinterface

// File: rtl/axis_rr_packet_mux.sv
// Round-robin AXI-Stream mux: packet-granular (or beat-granular) arbitration
// with a one-stage registered output.
`timescale 1ns/1ps
module axis_rr_packet_mux #(
  parameter int unsigned CHANNEL_NUM = 4,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ARB_MODE    = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  axis_rr_packet_mux_if.slave     s,
  axis_rr_packet_mux_if.master    m,
  output logic [CHANNEL_NUM-1:0]  sel_o
);

  localparam int unsigned ID_WIDTH = $clog2(CHANNEL_NUM);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e                state_q, state_d;
  logic [ID_WIDTH-1:0]   grant_q, grant_d;
  logic [ID_WIDTH-1:0]   last_grant_q, last_grant_d;
  logic                  m_tvalid_q, m_tvalid_d;
  logic                  m_tlast_q, m_tlast_d;
  logic [DATA_WIDTH-1:0] m_tdata_q, m_tdata_d;
  logic [ID_WIDTH-1:0]   m_tid_q, m_tid_d;

  logic                   ready_c;
  logic                   accept_c;
  logic                   found_c;
  logic [ID_WIDTH-1:0]    pick_c;
  logic [ID_WIDTH-1:0]    cand_c;
  logic [CHANNEL_NUM-1:0] tready_c;
  int unsigned            idx_c;

  // Rotating search for the next requester, starting just past the last grantee.
  always_comb begin
    found_c = 1'b0;
    pick_c  = '0;
    cand_c  = '0;
    idx_c   = 0;
    for (int unsigned i = 0; i < CHANNEL_NUM; i++) begin
      idx_c  = (32'(last_grant_q) + 32'd1 + i) % CHANNEL_NUM;
      cand_c = ID_WIDTH'(idx_c);
      if (!found_c && s.tvalid[cand_c]) begin
        found_c = 1'b1;
        pick_c  = cand_c;
      end
    end
  end

  // Next-state, grant and output-register logic.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    m_tvalid_d   = m_tvalid_q && !m.tready[0];
    m_tlast_d    = m_tlast_q;
    m_tdata_d    = m_tdata_q;
    m_tid_d      = m_tid_q;
    tready_c     = '0;
    ready_c      = (state_q == BUSY) && (!m_tvalid_q || m.tready[0]);
    accept_c     = ready_c && s.tvalid[grant_q];
    tready_c[grant_q] = ready_c;

    unique case (state_q)
      IDLE: begin
        if (found_c) begin
          state_d = BUSY;
          grant_d = pick_c;
        end
      end
      BUSY: begin
        if (accept_c) begin
          m_tvalid_d = 1'b1;
          m_tdata_d  = s.tdata[32'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
          m_tlast_d  = s.tlast[grant_q];
          m_tid_d    = grant_q;
          if (ARB_MODE != 0 || s.tlast[grant_q]) begin
            state_d      = IDLE;
            last_grant_d = grant_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= ID_WIDTH'(CHANNEL_NUM - 1);
      m_tvalid_q   <= 1'b0;
      m_tlast_q    <= 1'b0;
      m_tdata_q    <= '0;
      m_tid_q      <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      m_tvalid_q   <= m_tvalid_d;
      m_tlast_q    <= m_tlast_d;
      m_tdata_q    <= m_tdata_d;
      m_tid_q      <= m_tid_d;
    end
  end

  always_comb begin
    sel_o = '0;
    if (state_q == BUSY) sel_o[grant_q] = 1'b1;
  end

  assign s.tready = tready_c;
  assign m.tvalid = m_tvalid_q;
  assign m.tdata  = m_tdata_q;
  assign m.tlast  = m_tlast_q;
  assign m.tid    = m_tid_q;

endmodule

// File: tb/tb_axis_rr_packet_mux.sv
// Directed bench for axis_rr_packet_mux: cycle table plus multi-cycle arbitration scenarios.
`timescale 1ns/1ps
module tb_axis_rr_packet_mux;

  localparam int unsigned CN = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned IW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [CN-1:0] sel, bsel;

  always #5 clk = ~clk;

  axis_rr_packet_mux_if #(.NUM(CN), .DATA_WIDTH(DW), .ID_WIDTH(IW)) s_if ();
  axis_rr_packet_mux_if #(.NUM(1),  .DATA_WIDTH(DW), .ID_WIDTH(IW)) m_if ();
  axis_rr_packet_mux_if #(.NUM(CN), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bs_if ();
  axis_rr_packet_mux_if #(.NUM(1),  .DATA_WIDTH(DW), .ID_WIDTH(IW)) bm_if ();

  axis_rr_packet_mux #(.CHANNEL_NUM(CN), .DATA_WIDTH(DW), .ARB_MODE(0)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .s(s_if.slave), .m(m_if.master), .sel_o(sel));

  axis_rr_packet_mux #(.CHANNEL_NUM(CN), .DATA_WIDTH(DW), .ARB_MODE(1)) dut_beat (
    .clk_i(clk), .rst_n_i(rst_n), .s(bs_if.slave), .m(bm_if.master), .sel_o(bsel));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-channel packet sources for the multi-cycle scenarios.
  int src_len [CN];
  int src_beat[CN];
  logic [CN-1:0] hold;
  logic [10:0] capq[$];

  task automatic clear_src();
    for (int k = 0; k < CN; k++) begin
      src_len[k]  = 0;
      src_beat[k] = 0;
    end
    hold = '0;
    capq.delete();
  endtask

  task automatic drive_src();
    for (int k = 0; k < CN; k++) begin
      s_if.tvalid[k] = (src_len[k] > 0) && !hold[k];
      s_if.tlast[k]  = (src_len[k] == 1);
      s_if.tdata[k*DW +: DW] = 8'(k*16 + src_beat[k]);
    end
    m_if.tready = 1'b1;
  endtask

  task automatic src_cycle();
    logic [CN-1:0] acc;
    @(negedge clk);
    drive_src();
    #1;
    acc = s_if.tvalid & s_if.tready;
    if (m_if.tvalid && m_if.tready[0]) capq.push_back({m_if.tlast, m_if.tid, m_if.tdata});
    @(posedge clk);
    for (int k = 0; k < CN; k++) begin
      if (acc[k]) begin
        src_beat[k]++;
        src_len[k]--;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_src();
    s_if.tvalid = '0; s_if.tlast = '0; s_if.tdata = '0; s_if.tid = '0;
    bs_if.tvalid = '0; bs_if.tlast = '0; bs_if.tdata = '0; bs_if.tid = '0;
    m_if.tready = 1'b1; bm_if.tready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [3:0] vld;
    logic [3:0] lst;
    logic [7:0] d2;
    logic       rdy;
    logic [3:0] e_sel;
    logic [3:0] e_trdy;
    logic       e_mv;
    logic [7:0] e_md;
    logic       e_ml;
    logic [1:0] e_tid;
  } vec_t;

  vec_t tbl[14];

  initial begin
    tbl[0]  = '{4'b0000, 4'b0000, 8'h00, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0};
    tbl[1]  = '{4'b0100, 4'b0000, 8'hA1, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0};
    tbl[2]  = '{4'b0100, 4'b0000, 8'hA1, 1'b1, 4'b0100, 4'b0100, 1'b0, 8'h00, 1'b0, 2'd0};
    tbl[3]  = '{4'b1111, 4'b1011, 8'hA2, 1'b1, 4'b0100, 4'b0100, 1'b1, 8'hA1, 1'b0, 2'd2};
    tbl[4]  = '{4'b1111, 4'b1111, 8'hA3, 1'b0, 4'b0100, 4'b0000, 1'b1, 8'hA2, 1'b0, 2'd2};
    tbl[5]  = '{4'b1111, 4'b1111, 8'hA3, 1'b0, 4'b0100, 4'b0000, 1'b1, 8'hA2, 1'b0, 2'd2};
    tbl[6]  = '{4'b1111, 4'b1111, 8'hA3, 1'b0, 4'b0100, 4'b0000, 1'b1, 8'hA2, 1'b0, 2'd2};
    tbl[7]  = '{4'b1111, 4'b1111, 8'hA3, 1'b0, 4'b0100, 4'b0000, 1'b1, 8'hA2, 1'b0, 2'd2};
    tbl[8]  = '{4'b1111, 4'b0100, 8'hA3, 1'b1, 4'b0100, 4'b0100, 1'b1, 8'hA2, 1'b0, 2'd2};
    tbl[9]  = '{4'b0000, 4'b0000, 8'h00, 1'b1, 4'b0000, 4'b0000, 1'b1, 8'hA3, 1'b1, 2'd2};
    tbl[10] = '{4'b0000, 4'b0000, 8'h00, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0};
    tbl[11] = '{4'b0100, 4'b0100, 8'hB1, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0};
    tbl[12] = '{4'b0100, 4'b0100, 8'hB1, 1'b1, 4'b0100, 4'b0100, 1'b0, 8'h00, 1'b0, 2'd0};
    tbl[13] = '{4'b0000, 4'b0000, 8'h00, 1'b1, 4'b0000, 4'b0000, 1'b1, 8'hB1, 1'b1, 2'd2};

    // Reset values while reset is held.
    clear_src();
    s_if.tvalid = 4'b1111; s_if.tlast = '0; s_if.tdata = '1; s_if.tid = '0;
    bs_if.tvalid = '0; bs_if.tlast = '0; bs_if.tdata = '0; bs_if.tid = '0;
    m_if.tready = 1'b1; bm_if.tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mvalid", 32'(m_if.tvalid), 32'd0);
    chk("rst_mlast",  32'(m_if.tlast),  32'd0);
    chk("rst_mdata",  32'(m_if.tdata),  32'd0);
    chk("rst_mtid",   32'(m_if.tid),    32'd0);
    chk("rst_sel",    32'(sel),         32'd0);
    chk("rst_tready", 32'(s_if.tready), 32'd0);

    // Cycle table: lone channel 2, stall of 4 cycles, foreign toggles, re-grant.
    do_reset();
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      s_if.tvalid = tbl[i].vld;
      s_if.tlast  = tbl[i].lst;
      s_if.tdata  = {8'hEE, tbl[i].d2, 8'hEE, 8'hEE};
      m_if.tready = tbl[i].rdy;
      #1;
      chk($sformatf("tbl%0d_sel", i),    32'(sel),         32'(tbl[i].e_sel));
      chk($sformatf("tbl%0d_tready", i), 32'(s_if.tready), 32'(tbl[i].e_trdy));
      chk($sformatf("tbl%0d_mvalid", i), 32'(m_if.tvalid), 32'(tbl[i].e_mv));
      if (tbl[i].e_mv) begin
        chk($sformatf("tbl%0d_mdata", i), 32'(m_if.tdata), 32'(tbl[i].e_md));
        chk($sformatf("tbl%0d_mlast", i), 32'(m_if.tlast), 32'(tbl[i].e_ml));
        chk($sformatf("tbl%0d_mtid", i),  32'(m_if.tid),   32'(tbl[i].e_tid));
      end
    end

    // Four simultaneous 2-beat packets served in channel order, contiguously.
    do_reset();
    for (int k = 0; k < CN; k++) src_len[k] = 2;
    for (int c = 0; c < 40 && capq.size() < 8; c++) src_cycle();
    chk("rr4_count", 32'(capq.size()), 32'd8);
    for (int j = 0; j < 8 && j < capq.size(); j++)
      chk($sformatf("rr4_beat%0d", j), 32'(capq[j]),
          32'({(j % 2) == 1, 2'(j / 2), 8'((j / 2) * 16 + (j % 2))}));

    // Mid-packet tvalid gap on channel 1 keeps the grant; channel 3 waits.
    do_reset();
    src_len[1] = 4;
    src_len[3] = 2;
    for (int c = 0; c < 10 && src_beat[1] < 1; c++) src_cycle();
    chk("gap_started", 32'(src_beat[1]), 32'd1);
    hold[1] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      src_cycle();
      #1;
      chk($sformatf("gap_sel%0d", c), 32'(sel), 32'b0010);
      chk($sformatf("gap_ch3_idle%0d", c), 32'(src_beat[3]), 32'd0);
    end
    hold[1] = 1'b0;
    for (int c = 0; c < 40 && capq.size() < 6; c++) src_cycle();
    chk("gap_count", 32'(capq.size()), 32'd6);
    if (capq.size() == 6) begin
      chk("gap_b0", 32'(capq[0]), 32'({1'b0, 2'd1, 8'h10}));
      chk("gap_b1", 32'(capq[1]), 32'({1'b0, 2'd1, 8'h11}));
      chk("gap_b2", 32'(capq[2]), 32'({1'b0, 2'd1, 8'h12}));
      chk("gap_b3", 32'(capq[3]), 32'({1'b1, 2'd1, 8'h13}));
      chk("gap_b4", 32'(capq[4]), 32'({1'b0, 2'd3, 8'h30}));
      chk("gap_b5", 32'(capq[5]), 32'({1'b1, 2'd3, 8'h31}));
    end

    // Asynchronous reset mid-packet on channel 2, then restart from channel 0.
    do_reset();
    src_len[2] = 4;
    for (int c = 0; c < 10 && src_beat[2] < 2; c++) src_cycle();
    chk("arst_started", 32'(src_beat[2]), 32'd2);
    #2;
    chk("arst_pre_mvalid", 32'(m_if.tvalid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_mvalid", 32'(m_if.tvalid), 32'd0);
    chk("arst_sel",    32'(sel),         32'd0);
    chk("arst_tready", 32'(s_if.tready), 32'd0);
    clear_src();
    for (int k = 0; k < CN; k++) src_len[k] = 2;
    drive_src();
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("arst_hold_mvalid", 32'(m_if.tvalid), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("arst_rel_sel", 32'(sel), 32'd0);
    @(posedge clk);
    #1;
    chk("arst_first_grant", 32'(sel), 32'b0001);

    // Beat mode: two always-valid channels alternate every beat.
    do_reset();
    bs_if.tvalid = 4'b0011;
    bs_if.tlast  = 4'b0000;
    bs_if.tdata  = 32'h0000_2211;
    begin
      logic [1:0] tids[$];
      for (int c = 0; c < 40 && tids.size() < 6; c++) begin
        @(negedge clk);
        #1;
        if (bm_if.tvalid) tids.push_back(bm_if.tid);
      end
      chk("beat_count", 32'(tids.size()), 32'd6);
      for (int j = 0; j < tids.size(); j++)
        chk($sformatf("beat_tid%0d", j), 32'(tids[j]), 32'(j % 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axis_rr_packet_mux.md
AXIS_RR_PACKET_MUX -- requirements
Module: axis_rr_packet_mux

Interface
REQ-001 Parameter CHANNEL_NUM, default 4: number of slave AXI-Stream inputs; legal range 2..16.
REQ-002 Parameter DATA_WIDTH, default 32: tdata width in bits; legal range 8..512.
REQ-003 Parameter ARB_MODE, default 0: 0 = packet mode (grant held until tlast beat); 1 = beat mode (re-arbitrate after every beat).
REQ-004 Localparam ID_WIDTH SHALL equal $clog2(CHANNEL_NUM).
REQ-005 clk_i  input  1  sole clock; all state changes on its rising edge.
REQ-006 rst_n_i  input  1  reset, asynchronous assert, active-low.
REQ-007 s_tvalid  input  CHANNEL_NUM  per-channel valid.
REQ-008 s_tready  output  CHANNEL_NUM  per-channel ready.
REQ-009 s_tdata  input  CHANNEL_NUM*DATA_WIDTH  channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-010 s_tlast  input  CHANNEL_NUM  per-channel end of packet.
REQ-011 m_tvalid  output  1  output valid.
REQ-012 m_tready  input  1  downstream ready.
REQ-013 m_tdata  output  DATA_WIDTH  output data.
REQ-014 m_tlast  output  1  output end of packet.
REQ-015 m_tid  output  ID_WIDTH  index of the source channel of the current output beat.
REQ-016 sel_o  output  CHANNEL_NUM  one-hot current grant; all zeros when no grant.

Function
REQ-017 FSM states: IDLE (no grant) and BUSY (one channel granted).
REQ-018 In IDLE, when any s_tvalid bit is 1, the block SHALL grant the first requesting channel searching upward from (last_grant+1) mod CHANNEL_NUM with wrap-around, and enter BUSY on the next edge.
REQ-019 Channels with s_tvalid=0 SHALL be skipped without consuming a cycle (work-conserving).
REQ-020 In IDLE with s_tvalid all zeros, the block SHALL stay in IDLE with sel_o=0 and s_tready=0.
REQ-021 In BUSY, sel_o SHALL be one-hot on the granted channel, and only that channel's s_tready may be 1.
REQ-022 s_tready[g] SHALL equal (state==BUSY) && (!m_tvalid || m_tready); all other bits are 0.
REQ-023 A beat is accepted when s_tvalid[g] && s_tready[g]; tdata, tlast and g SHALL be registered into m_tdata, m_tlast and m_tid, with m_tvalid=1 on the next edge (1-cycle latency).
REQ-024 m_tvalid SHALL clear on the edge where m_tready=1 and no new beat is accepted; m_tdata, m_tlast and m_tid SHALL be held stable while m_tvalid && !m_tready.
REQ-025 Packet mode: an accepted beat with tlast=1 SHALL move the FSM to IDLE and set last_grant=g; a deassertion of s_tvalid[g] mid-packet SHALL keep the grant (no timeout).
REQ-026 Beat mode: every accepted beat SHALL move the FSM to IDLE and set last_grant=g.
REQ-027 Arbitration cost: after a packet's last beat is accepted, the next grant SHALL appear 1 cycle later (IDLE) and the next accept at the earliest 2 cycles later.
REQ-028 If the only requester is the previous grantee, it SHALL be re-granted.
REQ-029 Changes to s_tvalid or s_tlast on non-granted channels SHALL have no effect during BUSY.

Reset
REQ-030 While rst_n_i=0: state=IDLE, last_grant=CHANNEL_NUM-1 (first search starts at channel 0), m_tvalid=0, m_tlast=0, m_tdata=0, m_tid=0, sel_o=0, s_tready=0.
REQ-031 Reset asserted mid-packet SHALL discard the partial packet immediately, with no further output beats; after release, arbitration restarts from channel 0.
REQ-032 The first grant after reset release SHALL occur no earlier than the first rising edge with rst_n_i=1.

Verification (CHANNEL_NUM=4, DATA_WIDTH=8, m_tready=1 unless stated)
REQ-033 Channels 0–3 each send a 2-beat packet simultaneously after reset -> m_tid sequence 0,0,1,1,2,2,3,3; every packet is contiguous; m_tlast=1 on beats 2,4,6,8.
REQ-034 Only channel 2 is valid, with a 3-beat packet 0xA1,0xA2,0xA3 -> sel_o=4'b0100 one cycle after valid; m_tdata sequence A1,A2,A3 with tid=2; then IDLE.
REQ-035 Packet mode: channel 1 is mid-packet and drops tvalid for 5 cycles while channel 3 is valid -> sel_o stays 4'b0010; channel 3 is not served until channel 1's tlast beat is accepted.
REQ-036 m_tready held at 0 for 4 cycles during a packet -> m_tvalid=1 and m_tdata stable throughout; s_tready[g]=0 throughout; no beat lost or duplicated.
REQ-037 ARB_MODE=1 with channels 0 and 1 continuously valid -> m_tid alternates 0,1,0,1 regardless of tlast.
REQ-038 rst_n_i pulsed low mid-packet on channel 2 -> m_tvalid=0 and sel_o=0 asynchronously; after release with all channels valid, the first grant goes to channel 0.
